cde_prescale_monitor: RTL and testbench
=======================================

Name: cde_prescale_monitor

Overview:
Receive-side checker for a periodic single-cycle tick, such as the output of the team's prescaler. It measures the number of clk cycles between tick events and compares each period against an expected value. A lock state machine reports when the tick stream is stable, and sticky flags record period and timeout errors. It sits next to any tick consumer (UART baud, timers) as a health monitor.

Parameters:
EXP_PERIOD, 13, expected cycles between ticks (prescaler PRESCALE+1)
TOL, 0, allowed absolute deviation of measured period from EXP_PERIOD
LOCK_COUNT, 4, consecutive matching periods required to lock (>=1)
TIMEOUT, 26, cycles without a tick that declare loss (2..2^CNT_SIZE-1)
CNT_SIZE, 8, width of period counter and period_out

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
tick_in  input  1  tick event; every cycle it is high counts as one event
clear_err  input  1  clears sticky error flags
period_out  output  CNT_SIZE  last measured period, in cycles
period_valid  output  1  one-cycle pulse: period_out updated
locked  output  1  tick stream stable
err_period  output  1  sticky: mismatch seen while LOCKED
err_timeout  output  1  sticky: tick lost while ACQUIRE/LOCKED

Behaviour:
- Reset:
  - reset has priority over all inputs, including tick_in.
  - State goes to IDLE; cnt, match_cnt, period_out, period_valid, locked, err_period and err_timeout all go to 0.
- All outputs are registered. Every response is visible the cycle after the triggering input.
- Internal cnt (CNT_SIZE bits) holds cycles since the last tick, minus 1:
  - tick_in high: measured period = cnt+1, saturating at all-ones; cnt <= 0.
  - Otherwise cnt <= cnt+1, saturating at all-ones.
  - In IDLE, cnt is held at 0.
- match = |period - EXP_PERIOD| <= TOL. Compute with enough width to avoid wrap.
- States:
  - IDLE:
    - Tick: go to ACQUIRE, match_cnt <= 0.
    - No period_valid, because there is no prior reference tick.
  - ACQUIRE:
    - Each tick: period_out <= period, period_valid pulses.
    - Match with match_cnt == LOCK_COUNT-1: go to LOCKED, locked <= 1.
    - Match otherwise: match_cnt++.
    - Mismatch: match_cnt <= 0, stay in ACQUIRE, no error flag.
  - LOCKED:
    - Each tick: period_out <= period, period_valid pulses.
    - Mismatch: err_period <= 1, locked <= 0, match_cnt <= 0, go to ACQUIRE.
- Timeout:
  - Condition: state ACQUIRE or LOCKED, cnt == TIMEOUT-1 and tick_in low.
  - Action: err_timeout <= 1, locked <= 0, go to IDLE. No period_valid.
  - A tick arriving exactly when cnt == TIMEOUT-1 is a normal period (TIMEOUT) and is checked for match; it is not a timeout.
- clear_err:
  - Clears both sticky flags on the next edge.
  - If an error event occurs in the same cycle, setting wins and that flag stays 1.
- Back-to-back ticks (tick_in high on consecutive cycles) give period 1 on each.
- Reset mid-operation abandons any measurement. The first tick after reset is treated as an IDLE tick.
- Implementation constraint: TIMEOUT <= 2^CNT_SIZE-1, so timeout always fires before cnt saturates.

Test Plan:
1. Defaults, ticks every 13 cycles starting at first cycle after reset:
   - period_valid with period_out=13 on ticks 2 onward.
   - locked=1 the cycle after tick 5; no error flags.
2. Locked, then one period of 12:
   - period_out=12, err_period=1, locked=0.
   - After 4 further 13-cycle periods, locked=1 and err_period still 1.
3. Locked, tick stops (last tick at t=0):
   - err_timeout=1 and locked=0 at t=26.
   - Next tick gives no period_valid; the tick after that gives a period_valid.
4. In ACQUIRE, tick_in high two consecutive cycles -> period_out=1, match_cnt reset, no error flags.
5. clear_err asserted in the same cycle as a LOCKED mismatch -> err_period=1. clear_err alone -> err_period=0 next cycle.
6. reset asserted while LOCKED with tick_in high:
   - All outputs 0 next cycle.
   - First post-reset tick gives no period_valid; second tick 13 cycles later gives period_out=13.

Source files
------------

// File: rtl/cde_prescale_monitor_if.sv
// Tick/flag bundle for cde_prescale_monitor: the tick source side drives
// tick_in and clear_err, the monitor drives the measurement and health flags.
interface cde_prescale_monitor_if #(
  parameter int CNT_SIZE = 8
);
  logic                tick_in;
  logic                clear_err;
  logic [CNT_SIZE-1:0] period_out;
  logic                period_valid;
  logic                locked;
  logic                err_period;
  logic                err_timeout;

  modport master (
    output tick_in, clear_err,
    input  period_out, period_valid, locked, err_period, err_timeout
  );

  modport slave (
    input  tick_in, clear_err,
    output period_out, period_valid, locked, err_period, err_timeout
  );
endinterface

// File: rtl/cde_prescale_monitor.sv
// Receive-side health monitor for a periodic single-cycle tick: measures
// tick-to-tick period, tracks lock, and records sticky period/timeout errors.
module cde_prescale_monitor #(
  parameter int EXP_PERIOD = 13,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 26,
  parameter int CNT_SIZE   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  cde_prescale_monitor_if.slave   bus
);

  localparam int MW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam logic [CNT_SIZE-1:0] CNT_MAX = {CNT_SIZE{1'b1}};
  localparam logic [CNT_SIZE-1:0] TO_LAST = CNT_SIZE'(TIMEOUT - 1);
  localparam logic [MW-1:0]       MC_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [CNT_SIZE:0]   EXP_W   = (CNT_SIZE + 1)'(EXP_PERIOD);
  localparam logic [CNT_SIZE:0]   TOL_W   = (CNT_SIZE + 1)'(TOL);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [CNT_SIZE-1:0] cnt, cnt_n;
  logic [MW-1:0]       match_cnt, match_cnt_n;
  logic [CNT_SIZE-1:0] period_out, period_out_n;
  logic                period_valid, period_valid_n;
  logic                locked, locked_n;
  logic                err_period, err_period_n;
  logic                err_timeout, err_timeout_n;

  logic [CNT_SIZE-1:0] cnt_inc;
  logic [CNT_SIZE:0]   period_w;
  logic [CNT_SIZE:0]   diff;
  logic                match;
  logic                timeout;

  // Saturating increment doubles as the measured period (cnt holds cycles-1);
  // the deviation is taken one bit wider so neither subtraction can wrap.
  always_comb begin
    cnt_inc  = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_SIZE'(1);
    period_w = {1'b0, cnt_inc};
    if (period_w >= EXP_W) begin
      diff = period_w - EXP_W;
    end else begin
      diff = EXP_W - period_w;
    end
    match   = (diff <= TOL_W);
    timeout = (cnt == TO_LAST) && !bus.tick_in;
  end

  // Next-state and output decode; a sticky flag set in a given cycle
  // overrides a simultaneous clear_err.
  always_comb begin
    state_n        = state;
    cnt_n          = bus.tick_in ? {CNT_SIZE{1'b0}} : cnt_inc;
    match_cnt_n    = match_cnt;
    period_out_n   = period_out;
    period_valid_n = 1'b0;
    locked_n       = locked;
    err_period_n   = bus.clear_err ? 1'b0 : err_period;
    err_timeout_n  = bus.clear_err ? 1'b0 : err_timeout;

    case (state)
      IDLE: begin
        cnt_n = {CNT_SIZE{1'b0}};
        if (bus.tick_in) begin
          state_n     = ACQUIRE;
          match_cnt_n = {MW{1'b0}};
        end else begin
          state_n = IDLE;
        end
      end
      ACQUIRE: begin
        if (bus.tick_in) begin
          period_out_n   = cnt_inc;
          period_valid_n = 1'b1;
          if (match && (match_cnt == MC_LAST)) begin
            state_n  = LOCKED;
            locked_n = 1'b1;
          end else if (match) begin
            match_cnt_n = match_cnt + MW'(1);
          end else begin
            match_cnt_n = {MW{1'b0}};
          end
        end else if (timeout) begin
          state_n       = IDLE;
          cnt_n         = {CNT_SIZE{1'b0}};
          locked_n      = 1'b0;
          err_timeout_n = 1'b1;
        end else begin
          state_n = ACQUIRE;
        end
      end
      LOCKED: begin
        if (bus.tick_in) begin
          period_out_n   = cnt_inc;
          period_valid_n = 1'b1;
          if (!match) begin
            state_n      = ACQUIRE;
            match_cnt_n  = {MW{1'b0}};
            locked_n     = 1'b0;
            err_period_n = 1'b1;
          end else begin
            state_n = LOCKED;
          end
        end else if (timeout) begin
          state_n       = IDLE;
          cnt_n         = {CNT_SIZE{1'b0}};
          locked_n      = 1'b0;
          err_timeout_n = 1'b1;
        end else begin
          state_n = LOCKED;
        end
      end
      default: begin
        state_n     = IDLE;
        cnt_n       = {CNT_SIZE{1'b0}};
        match_cnt_n = {MW{1'b0}};
        locked_n    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset outranks every input including tick_in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= {CNT_SIZE{1'b0}};
      match_cnt    <= {MW{1'b0}};
      period_out   <= {CNT_SIZE{1'b0}};
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err_period   <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      match_cnt    <= match_cnt_n;
      period_out   <= period_out_n;
      period_valid <= period_valid_n;
      locked       <= locked_n;
      err_period   <= err_period_n;
      err_timeout  <= err_timeout_n;
    end
  end

  assign bus.period_out   = period_out;
  assign bus.period_valid = period_valid;
  assign bus.locked       = locked;
  assign bus.err_period   = err_period;
  assign bus.err_timeout  = err_timeout;

endmodule

// File: tb/tb_cde_prescale_monitor.sv
// Directed bench for cde_prescale_monitor: expected periods go into a
// scoreboard queue, a negedge monitor pops them on every period_valid.
module tb_cde_prescale_monitor;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   exp_q[$];

  cde_prescale_monitor_if #(.CNT_SIZE(8)) bus ();

  cde_prescale_monitor #(
    .EXP_PERIOD(13), .TOL(0), .LOCK_COUNT(4), .TIMEOUT(26), .CNT_SIZE(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every period_valid must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && bus.period_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_period_valid: got period_out=%0d, expected no pulse",
                 bus.period_out);
      end else begin
        chk("period_out", int'(bus.period_out), exp_q.pop_front());
      end
    end
  end

  // Apply one cycle of inputs; outputs reflect them on return.
  task automatic step(input logic t, input logic c);
    bus.tick_in   = t;
    bus.clear_err = c;
    @(posedge clk);
    #1;
    bus.tick_in   = 1'b0;
    bus.clear_err = 1'b0;
  endtask

  task automatic do_tick(input bit exp_pv, input int p, input logic c);
    if (exp_pv) exp_q.push_back(p);
    step(1'b1, c);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic chk_flags(input string tag, input int lk, input int ep, input int et);
    chk({tag, "_locked"}, int'(bus.locked), lk);
    chk({tag, "_err_period"}, int'(bus.err_period), ep);
    chk({tag, "_err_timeout"}, int'(bus.err_timeout), et);
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    reset         = 1'b1;
    bus.tick_in   = 1'b0;
    bus.clear_err = 1'b0;
    gap(2);
    chk("rst_period_out", int'(bus.period_out), 0);
    chk("rst_period_valid", int'(bus.period_valid), 0);
    chk_flags("rst", 0, 0, 0);
    reset = 1'b0;

    // 1: 13-cycle ticks, lock after tick 5
    do_tick(1'b0, 0, 1'b0);
    for (int i = 2; i <= 5; i++) begin
      gap(12);
      do_tick(1'b1, 13, 1'b0);
      if (i == 4) chk("t1_not_locked_tick4", int'(bus.locked), 0);
    end
    chk_flags("t1_lock", 1, 0, 0);

    // 2: one short period while locked, then relock with error sticky
    gap(11);
    do_tick(1'b1, 12, 1'b0);
    chk_flags("t2_mismatch", 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      gap(12);
      do_tick(1'b1, 13, 1'b0);
    end
    chk_flags("t2_relock", 1, 1, 0);

    // 5: clear_err coincident with a locked mismatch, then clear alone
    gap(11);
    do_tick(1'b1, 12, 1'b1);
    chk_flags("t5_set_wins", 0, 1, 0);
    step(1'b0, 1'b1);
    chk("t5_cleared_err_period", int'(bus.err_period), 0);
    gap(11);
    for (int i = 0; i < 4; i++) begin
      do_tick(1'b1, 13, 1'b0);
      if (i < 3) gap(12);
    end
    chk_flags("t5_relock", 1, 0, 0);

    // 3: tick stops while locked; timeout at t=26
    gap(25);
    chk_flags("t3_before_timeout", 1, 0, 0);
    step(1'b0, 1'b0);
    chk_flags("t3_timeout", 0, 0, 1);
    step(1'b0, 1'b1);
    chk("t3_cleared_err_timeout", int'(bus.err_timeout), 0);
    do_tick(1'b0, 0, 1'b0);
    // tick exactly at cnt == TIMEOUT-1 is a period of 26, not a timeout
    gap(25);
    do_tick(1'b1, 26, 1'b0);
    chk_flags("t3_boundary_tick", 0, 0, 0);

    // 4: back-to-back ticks in ACQUIRE give period 1 and reset match_cnt
    gap(12);
    do_tick(1'b1, 13, 1'b0);
    do_tick(1'b1, 1, 1'b0);
    chk_flags("t4_b2b", 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      gap(12);
      do_tick(1'b1, 13, 1'b0);
      chk("t4_relock_progress", int'(bus.locked), (i == 3) ? 1 : 0);
    end

    // 6: reset while locked with tick_in high
    gap(5);
    reset = 1'b1;
    step(1'b1, 1'b0);
    reset = 1'b0;
    chk("t6_period_out", int'(bus.period_out), 0);
    chk("t6_period_valid", int'(bus.period_valid), 0);
    chk_flags("t6_rst", 0, 0, 0);
    do_tick(1'b0, 0, 1'b0);
    gap(12);
    do_tick(1'b1, 13, 1'b0);
    chk("t6_not_locked", int'(bus.locked), 0);

    gap(3);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
